// File: rtl/vscale_dmem_responder.sv
// vscale_dmem_responder: wait-state SRAM slave for the vscale dmem port.
// Define VSCALE_DMEM_BADMEM_EN to enable misalignment and range checks.
package vscale_dmem_pkg;
  localparam int XPR_LEN = 32;
  localparam int MEM_TYPE_WIDTH = 3;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_B = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_H = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_W = 3'd2;
endpackage

module vscale_dmem_responder
  import vscale_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [XPR_LEN-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dmem_en,
  input  logic                      dmem_wen,
  input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [XPR_LEN-1:0]        dmem_addr,
  input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
  output logic [XPR_LEN-1:0]        dmem_rdata,
  output logic                      dmem_wait,
  output logic                      dmem_badmem_e
);

  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

  logic [XPR_LEN-1:0] mem [DEPTH_WORDS];

  state_t          state;
  logic [3:0]      cnt;
  logic [IDXW-1:0] idx_q;
  logic            wen_q;
  logic [3:0]      be_q;
  logic            bad_q;

  logic            capture;
  logic            size_b;
  logic            size_h;
  logic [3:0]      be_base;
  logic [3:0]      be_c;
  logic            bad_c;
  logic [IDXW-1:0] idx_c;
  logic            fwd;
  logic            store_go;
  logic [XPR_LEN-1:0] rd_word;
  logic [XPR_LEN-1:0] rd_now;

  assign dmem_wait = (state == WAIT);
  assign capture   = dmem_en & ~dmem_wait;
  assign size_b    = (dmem_size == MEM_TYPE_B);
  assign size_h    = (dmem_size == MEM_TYPE_H);

  // BASE_ADDR is aligned to the array size, so the index is a bit slice
  assign idx_c = dmem_addr[IDXW+1:2];

  always_comb begin
    be_base = 4'b1111;
    unique case (1'b1)
      size_b:  be_base = 4'b0001;
      size_h:  be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
  end

  assign be_c = be_base << dmem_addr[1:0];

`ifdef VSCALE_DMEM_BADMEM_EN
  logic misal;
  logic oor;
  assign misal = (size_h & dmem_addr[0]) |
                 (~size_b & ~size_h & |dmem_addr[1:0]);
  assign oor   = dmem_addr[XPR_LEN-1:IDXW+2] !=
                 BASE_ADDR[XPR_LEN-1:IDXW+2];
  assign bad_c = misal | oor;
`else
  logic unused_addr;
  assign unused_addr = ^dmem_addr[XPR_LEN-1:IDXW+2];
  assign bad_c = 1'b0;
`endif

  assign dmem_badmem_e = dmem_en & bad_c;

  assign store_go = (state == DATA) & wen_q & ~bad_q;

  // a store retiring this edge must be visible to a same-edge load
  assign fwd = ZERO_WAIT & store_go & (idx_q == idx_c);

  always_comb begin
    rd_word = mem[idx_c];
    for (int i = 0; i < 4; i++) begin
      if (fwd && be_q[i]) begin
        rd_word[8*i +: 8] = dmem_wdata_delayed[8*i +: 8];
      end
    end
  end

  assign rd_now = (dmem_wen | bad_c) ? '0 : rd_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      idx_q      <= '0;
      wen_q      <= 1'b0;
      be_q       <= 4'd0;
      bad_q      <= 1'b0;
      dmem_rdata <= '0;
    end else begin
      unique case (state)
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= DATA;
            dmem_rdata <= (wen_q | bad_q) ? '0 : mem[idx_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (capture) begin
            idx_q <= idx_c;
            wen_q <= dmem_wen;
            be_q  <= be_c;
            bad_q <= bad_c;
            if (ZERO_WAIT) begin
              state      <= DATA;
              dmem_rdata <= rd_now;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store_go) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= dmem_wdata_delayed[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// tb_vscale_dmem_responder: directed checks on three responder instances
// with zero, three and two wait states.
module tb_vscale_dmem_responder;

  logic             clk;
  logic [2:0]       rst;
  logic [2:0]       en;
  logic [2:0]       wen;
  logic [2:0][2:0]  size;
  logic [2:0][31:0] addr;
  logic [2:0][31:0] wdata;
  logic [2:0][31:0] rdata;
  logic [2:0]       wt;
  logic [2:0]       bad;

  int checks;
  int failures;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;

  vscale_dmem_responder #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(rst[0]), .dmem_en(en[0]), .dmem_wen(wen[0]),
    .dmem_size(size[0]), .dmem_addr(addr[0]),
    .dmem_wdata_delayed(wdata[0]), .dmem_rdata(rdata[0]),
    .dmem_wait(wt[0]), .dmem_badmem_e(bad[0])
  );

  vscale_dmem_responder #(.WAIT_CYCLES(3)) u1 (
    .clk(clk), .reset(rst[1]), .dmem_en(en[1]), .dmem_wen(wen[1]),
    .dmem_size(size[1]), .dmem_addr(addr[1]),
    .dmem_wdata_delayed(wdata[1]), .dmem_rdata(rdata[1]),
    .dmem_wait(wt[1]), .dmem_badmem_e(bad[1])
  );

  vscale_dmem_responder #(.WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(rst[2]), .dmem_en(en[2]), .dmem_wen(wen[2]),
    .dmem_size(size[2]), .dmem_addr(addr[2]),
    .dmem_wdata_delayed(wdata[2]), .dmem_rdata(rdata[2]),
    .dmem_wait(wt[2]), .dmem_badmem_e(bad[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_bus(input int d);
    en[d] = 1'b0; wen[d] = 1'b0; size[d] = SZ_W;
    addr[d] = 32'h0; wdata[d] = 32'h0;
  endtask

  task automatic req(input int d, input logic w,
                     input logic [2:0] s, input logic [31:0] a);
    en[d] = 1'b1; wen[d] = w; size[d] = s; addr[d] = a;
  endtask

  task automatic test_reset;
    rst = 3'b000;
    for (int d = 0; d < 3; d++) idle_bus(d);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (wt[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_wait[%0d] got=%b exp=0", d, wt[d]);
      end
    end
    checks++;
    if (rdata[0] !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", rdata[0]);
    end
    checks++;
    if (bad[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_badmem got=%b exp=0", bad[0]);
    end
    rst = 3'b111;
    @(negedge clk);
  endtask

  task automatic test_word_forward;
    req(0, 1'b1, SZ_W, 32'h10);
    @(negedge clk);
    checks++;
    if (wt[0] !== 1'b0) begin
      failures++;
      $display("FAIL fwd_wait_store got=%b exp=0", wt[0]);
    end
    wdata[0] = 32'hDEADBEEF;
    req(0, 1'b0, SZ_W, 32'h10);
    @(negedge clk);
    checks++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL fwd_word got=%h exp=deadbeef", rdata[0]);
    end
    checks++;
    if (wt[0] !== 1'b0) begin
      failures++;
      $display("FAIL fwd_wait_load got=%b exp=0", wt[0]);
    end
    req(0, 1'b1, SZ_B, 32'h11);
    @(negedge clk);
    wdata[0] = 32'h55555555;
    req(0, 1'b0, SZ_W, 32'h10);
    @(negedge clk);
    idle_bus(0);
    checks++;
    if (rdata[0] !== 32'hDEAD55EF) begin
      failures++;
      $display("FAIL fwd_byte_merge got=%h exp=dead55ef", rdata[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_lanes;
    req(0, 1'b1, SZ_W, 32'h20);
    @(negedge clk);
    wdata[0] = 32'h0;
    req(0, 1'b1, SZ_B, 32'h21);
    @(negedge clk);
    wdata[0] = 32'hAAAAAAAA;
    req(0, 1'b1, SZ_H, 32'h22);
    @(negedge clk);
    wdata[0] = 32'h12341234;
    en[0] = 1'b0;
    @(negedge clk);
    wdata[0] = 32'h0;
    req(0, 1'b0, SZ_W, 32'h20);
    @(negedge clk);
    idle_bus(0);
    checks++;
    if (rdata[0] !== 32'h1234AA00) begin
      failures++;
      $display("FAIL lanes_word got=%h exp=1234aa00", rdata[0]);
    end
    req(0, 1'b0, SZ_W, 32'h10);
    @(negedge clk);
    idle_bus(0);
    checks++;
    if (rdata[0] !== 32'hDEAD55EF) begin
      failures++;
      $display("FAIL lanes_reread got=%h exp=dead55ef", rdata[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_states;
    req(1, 1'b1, SZ_W, 32'h40);
    @(negedge clk);
    req(1, 1'b0, SZ_W, 32'h40);
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (wt[1] !== 1'b1) begin
        failures++;
        $display("FAIL ws_store_wait c%0d got=%b exp=1", i, wt[1]);
      end
      @(negedge clk);
    end
    checks++;
    if (wt[1] !== 1'b0) begin
      failures++;
      $display("FAIL ws_store_data got=%b exp=0", wt[1]);
    end
    checks++;
    if (rdata[1] !== 32'h0) begin
      failures++;
      $display("FAIL ws_store_rdata got=%h exp=0", rdata[1]);
    end
    wdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    wdata[1] = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (wt[1] !== 1'b1) begin
        failures++;
        $display("FAIL ws_load_wait c%0d got=%b exp=1", i, wt[1]);
      end
      @(negedge clk);
    end
    checks++;
    if (wt[1] !== 1'b0 || rdata[1] !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL ws_load_data got=%b/%h exp=0/cafef00d",
               wt[1], rdata[1]);
    end
    @(negedge clk);
    idle_bus(1);
    checks++;
    if (wt[1] !== 1'b1) begin
      failures++;
      $display("FAIL ws_held_capture got=%b exp=1", wt[1]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wt[1] !== 1'b0 || rdata[1] !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL ws_held_data got=%b/%h exp=0/cafef00d",
               wt[1], rdata[1]);
    end
    @(negedge clk);
    checks++;
    if (wt[1] !== 1'b0) begin
      failures++;
      $display("FAIL ws_idle got=%b exp=0", wt[1]);
    end
  endtask

  task automatic test_bad_access;
`ifdef VSCALE_DMEM_BADMEM_EN
    req(0, 1'b1, SZ_W, 32'h4);
    #1;
    checks++;
    if (bad[0] !== 1'b0) begin
      failures++;
      $display("FAIL bad_aligned got=%b exp=0", bad[0]);
    end
    @(negedge clk);
    wdata[0] = 32'h01020304;
    req(0, 1'b1, SZ_W, 32'h6);
    #1;
    checks++;
    if (bad[0] !== 1'b1) begin
      failures++;
      $display("FAIL bad_misal_word got=%b exp=1", bad[0]);
    end
    @(negedge clk);
    wdata[0] = 32'hFFFFFFFF;
    req(0, 1'b0, SZ_W, 32'h4);
    @(negedge clk);
    idle_bus(0);
    checks++;
    if (rdata[0] !== 32'h01020304) begin
      failures++;
      $display("FAIL bad_store_dropped got=%h exp=01020304", rdata[0]);
    end
    req(0, 1'b0, SZ_W, 32'h1000);
    #1;
    checks++;
    if (bad[0] !== 1'b1) begin
      failures++;
      $display("FAIL bad_range got=%b exp=1", bad[0]);
    end
    @(negedge clk);
    idle_bus(0);
    checks++;
    if (rdata[0] !== 32'h0) begin
      failures++;
      $display("FAIL bad_load_rdata got=%h exp=0", rdata[0]);
    end
    req(0, 1'b0, SZ_H, 32'h21);
    #1;
    checks++;
    if (bad[0] !== 1'b1) begin
      failures++;
      $display("FAIL bad_misal_half got=%b exp=1", bad[0]);
    end
    req(0, 1'b0, SZ_B, 32'h23);
    #1;
    checks++;
    if (bad[0] !== 1'b0) begin
      failures++;
      $display("FAIL bad_byte_ok got=%b exp=0", bad[0]);
    end
    @(negedge clk);
    idle_bus(0);
`else
    req(0, 1'b1, SZ_W, 32'h1000);
    #1;
    checks++;
    if (bad[0] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_badmem got=%b exp=0", bad[0]);
    end
    @(negedge clk);
    wdata[0] = 32'h11223344;
    en[0] = 1'b0;
    @(negedge clk);
    wdata[0] = 32'h0;
    req(0, 1'b0, SZ_W, 32'h6);
    #1;
    checks++;
    if (bad[0] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_misal got=%b exp=0", bad[0]);
    end
    req(0, 1'b0, SZ_W, 32'h0);
    @(negedge clk);
    idle_bus(0);
    checks++;
    if (rdata[0] !== 32'h11223344) begin
      failures++;
      $display("FAIL wrap_load got=%h exp=11223344", rdata[0]);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    req(2, 1'b1, SZ_W, 32'h30);
    @(negedge clk);
    en[2] = 1'b0;
    repeat (2) @(negedge clk);
    wdata[2] = 32'h5A5A5A5A;
    @(negedge clk);
    wdata[2] = 32'h0;
    req(2, 1'b1, SZ_W, 32'h30);
    @(negedge clk);
    checks++;
    if (wt[2] !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_wait got=%b exp=1", wt[2]);
    end
    en[2] = 1'b0;
    wdata[2] = 32'hFFFFFFFF;
    rst[2] = 1'b0;
    #1;
    checks++;
    if (wt[2] !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_wait got=%b exp=0", wt[2]);
    end
    repeat (2) @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (wt[2] !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle got=%b exp=0", wt[2]);
    end
    wdata[2] = 32'h0;
    req(2, 1'b0, SZ_W, 32'h30);
    @(negedge clk);
    idle_bus(2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (wt[2] !== 1'b0 || rdata[2] !== 32'h5A5A5A5A) begin
      failures++;
      $display("FAIL rst_old_data got=%b/%h exp=0/5a5a5a5a",
               wt[2], rdata[2]);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_word_forward();
    test_lanes();
    test_wait_states();
    test_bad_access();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
